// File: rtl/rename_state.sv
// Rename state for Tomasulo dispatch: 32x32 regfile, register status table, free-tag FIFO.
// Optional RENAME_CDB_BYPASS_EN forwards a matching CDB result onto the rs/rt read ports.
module rename_state #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        dispatch_rsaddr,
  input  logic [4:0]        dispatch_rtaddr,
  output logic [DATA_W-1:0] dispatch_rsdata,
  output logic [DATA_W-1:0] dispatch_rtdata,
  output logic [TAG_W-1:0]  dispatch_rstag,
  output logic [TAG_W-1:0]  dispatch_rttag,
  output logic              dispatch_rsvalid,
  output logic              dispatch_rtvalid,
  input  logic              dispatch_wen,
  input  logic [4:0]        dispatch_addr,
  input  logic              dispatch_ren,
  output logic [TAG_W-1:0]  dispatch_tag,
  output logic              dispatch_full,
  output logic              dispatch_empty,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [31:0]       regfile_wen_onehot,
  input  logic [4:0]        debug_addr,
  output logic [DATA_W-1:0] debug_data
);

  localparam int NUM_TAGS = 2 ** TAG_W;
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(NUM_TAGS);

  logic [DATA_W-1:0] regfile_q   [32];
  logic [DATA_W-1:0] regfile_d   [32];
  logic [31:0]       rst_valid_q, rst_valid_d;
  logic [TAG_W-1:0]  rst_tag_q   [32];
  logic [TAG_W-1:0]  rst_tag_d   [32];
  logic [TAG_W-1:0]  fifo_q      [NUM_TAGS];
  logic [TAG_W-1:0]  fifo_d      [NUM_TAGS];
  logic [TAG_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [TAG_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [TAG_W:0]    count_q, count_d;

  logic pop_en, push_en, rename_en;

  assign dispatch_full  = (count_q == FULL_CNT);
  assign dispatch_empty = (count_q == '0);
  assign dispatch_tag   = fifo_q[rd_ptr_q];

  assign pop_en    = dispatch_ren & ~dispatch_empty;
  // A freed tag arriving at full is only kept if a pop makes room the same cycle.
  assign push_en   = cdb_valid & (~dispatch_full | pop_en);
  assign rename_en = dispatch_wen & ~dispatch_empty & (dispatch_addr != 5'd0);

  always_comb begin
    regfile_wen_onehot = '0;
    for (int i = 1; i < 32; i++) begin
      if (cdb_valid && !rst_valid_q[i] && (rst_tag_q[i] == cdb_tag))
        regfile_wen_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    dispatch_rsdata  = regfile_q[dispatch_rsaddr];
    dispatch_rsvalid = rst_valid_q[dispatch_rsaddr];
    dispatch_rstag   = rst_tag_q[dispatch_rsaddr];
`ifdef RENAME_CDB_BYPASS_EN
    if (cdb_valid && !rst_valid_q[dispatch_rsaddr] && (rst_tag_q[dispatch_rsaddr] == cdb_tag)) begin
      dispatch_rsdata  = cdb_data;
      dispatch_rsvalid = 1'b1;
    end
`endif
    if (dispatch_rsaddr == 5'd0) begin
      dispatch_rsdata  = '0;
      dispatch_rsvalid = 1'b1;
    end
  end

  always_comb begin
    dispatch_rtdata  = regfile_q[dispatch_rtaddr];
    dispatch_rtvalid = rst_valid_q[dispatch_rtaddr];
    dispatch_rttag   = rst_tag_q[dispatch_rtaddr];
`ifdef RENAME_CDB_BYPASS_EN
    if (cdb_valid && !rst_valid_q[dispatch_rtaddr] && (rst_tag_q[dispatch_rtaddr] == cdb_tag)) begin
      dispatch_rtdata  = cdb_data;
      dispatch_rtvalid = 1'b1;
    end
`endif
    if (dispatch_rtaddr == 5'd0) begin
      dispatch_rtdata  = '0;
      dispatch_rtvalid = 1'b1;
    end
  end

  assign debug_data = (debug_addr == 5'd0) ? '0 : regfile_q[debug_addr];

  // Rename is applied after the CDB update so a same-cycle rename leaves the entry pending.
  always_comb begin
    regfile_d   = regfile_q;
    rst_valid_d = rst_valid_q;
    rst_tag_d   = rst_tag_q;
    for (int i = 1; i < 32; i++) begin
      if (regfile_wen_onehot[i]) begin
        regfile_d[i]   = cdb_data;
        rst_valid_d[i] = 1'b1;
      end
    end
    if (rename_en) begin
      rst_valid_d[dispatch_addr] = 1'b0;
      rst_tag_d[dispatch_addr]   = dispatch_tag;
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      fifo_d[wr_ptr_q] = cdb_tag;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop_en)
      rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_en && !pop_en)
      count_d = count_q + 1'b1;
    else if (pop_en && !push_en)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regfile_q[i] <= '0;
        rst_tag_q[i] <= '0;
      end
      rst_valid_q <= '1;
      for (int i = 0; i < NUM_TAGS; i++)
        fifo_q[i] <= TAG_W'(i);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= FULL_CNT;
    end else begin
      regfile_q   <= regfile_d;
      rst_valid_q <= rst_valid_d;
      rst_tag_q   <= rst_tag_d;
      fifo_q      <= fifo_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_rename_state.sv
// Scoreboard bench for rename_state: expectations are queued as stimulus is driven and
// compared once the DUT output for that step is available.
module tb_rename_state;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  dispatch_rsaddr, dispatch_rtaddr, dispatch_addr, debug_addr;
  logic [31:0] dispatch_rsdata, dispatch_rtdata, cdb_data, debug_data;
  logic [5:0]  dispatch_rstag, dispatch_rttag, dispatch_tag, cdb_tag;
  logic        dispatch_rsvalid, dispatch_rtvalid, dispatch_wen, dispatch_ren;
  logic        dispatch_full, dispatch_empty, cdb_valid;
  logic [31:0] regfile_wen_onehot;

  rename_state dut (
    .clk(clk), .reset(reset),
    .dispatch_rsaddr(dispatch_rsaddr), .dispatch_rtaddr(dispatch_rtaddr),
    .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
    .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
    .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
    .dispatch_wen(dispatch_wen), .dispatch_addr(dispatch_addr),
    .dispatch_ren(dispatch_ren), .dispatch_tag(dispatch_tag),
    .dispatch_full(dispatch_full), .dispatch_empty(dispatch_empty),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .regfile_wen_onehot(regfile_wen_onehot),
    .debug_addr(debug_addr), .debug_data(debug_data)
  );

  always #5 clk = ~clk;

`ifdef RENAME_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int F_RSDATA = 0, F_RSVALID = 1, F_RSTAG = 2, F_RTVALID = 3, F_DTAG = 4;
  localparam int F_FULL = 5, F_EMPTY = 6, F_ONEHOT = 7, F_DEBUG = 8;

  typedef struct {
    string       name;
    int          field;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string n, input int f, input logic [31:0] e);
    exp_t item;
    item.name = n; item.field = f; item.exp = e;
    sb.push_back(item);
  endtask

  function automatic logic [31:0] observe(input int f);
    case (f)
      F_RSDATA:  return dispatch_rsdata;
      F_RSVALID: return {31'd0, dispatch_rsvalid};
      F_RSTAG:   return {26'd0, dispatch_rstag};
      F_RTVALID: return {31'd0, dispatch_rtvalid};
      F_DTAG:    return {26'd0, dispatch_tag};
      F_FULL:    return {31'd0, dispatch_full};
      F_EMPTY:   return {31'd0, dispatch_empty};
      F_ONEHOT:  return regfile_wen_onehot;
      F_DEBUG:   return debug_data;
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.name, observe(e.field), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dispatch_wen = 1'b0; dispatch_ren = 1'b0; cdb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    dispatch_addr = 5'd0; cdb_tag = '0; cdb_data = '0;
    dispatch_rsaddr = 5'd5; dispatch_rtaddr = 5'd5; debug_addr = 5'd5;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    expect_val("rst_dtag", F_DTAG, 32'd0);
    expect_val("rst_full", F_FULL, 32'd1);
    expect_val("rst_empty", F_EMPTY, 32'd0);
    expect_val("rst_rsvalid", F_RSVALID, 32'd1);
    expect_val("rst_rsdata", F_RSDATA, 32'd0);
    drain();

    // rename r5 with head tag 0
    dispatch_wen = 1'b1; dispatch_addr = 5'd5; dispatch_ren = 1'b1;
    tick(); idle_inputs();
    expect_val("ren5_tag", F_RSTAG, 32'd0);
    expect_val("ren5_valid", F_RSVALID, 32'd0);
    expect_val("ren5_dtag", F_DTAG, 32'd1);
    expect_val("ren5_full", F_FULL, 32'd0);
    drain();

    // CDB completes tag 0
    cdb_valid = 1'b1; cdb_tag = 6'd0; cdb_data = 32'hDEADBEEF;
    #1;
    expect_val("cdb0_onehot", F_ONEHOT, 32'h20);
    expect_val("cdb0_byp_valid", F_RSVALID, {31'd0, BYP});
    drain();
    tick(); idle_inputs();
    expect_val("cdb0_debug", F_DEBUG, 32'hDEADBEEF);
    expect_val("cdb0_rsdata", F_RSDATA, 32'hDEADBEEF);
    expect_val("cdb0_rsvalid", F_RSVALID, 32'd1);
    expect_val("cdb0_full", F_FULL, 32'd1);
    expect_val("cdb0_dtag", F_DTAG, 32'd1);
    drain();

    // asynchronous reset mid-run
    dispatch_wen = 1'b1; dispatch_addr = 5'd5; dispatch_ren = 1'b1;
    tick(); idle_inputs();
    expect_val("pre_rst_valid", F_RSVALID, 32'd0);
    expect_val("pre_rst_dtag", F_DTAG, 32'd2);
    drain();
    #2 reset = 1'b1;
    #1;
    expect_val("arst_dtag", F_DTAG, 32'd0);
    expect_val("arst_full", F_FULL, 32'd1);
    expect_val("arst_empty", F_EMPTY, 32'd0);
    expect_val("arst_rsvalid", F_RSVALID, 32'd1);
    expect_val("arst_debug", F_DEBUG, 32'd0);
    drain();
    #1 reset = 1'b0;
    tick();

    // drain all 64 tags
    dispatch_ren = 1'b1;
    repeat (64) tick();
    idle_inputs();
    expect_val("drain_empty", F_EMPTY, 32'd1);
    expect_val("drain_full", F_FULL, 32'd0);
    drain();

    // rename while empty is ignored
    dispatch_wen = 1'b1; dispatch_addr = 5'd6; dispatch_ren = 1'b1; dispatch_rtaddr = 5'd6;
    tick(); idle_inputs();
    expect_val("empty_ren_rtvalid", F_RTVALID, 32'd1);
    expect_val("empty_pop_empty", F_EMPTY, 32'd1);
    drain();

    // freed tag 7 refills the FIFO, no register is pending on it
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'h0000ABCD;
    #1;
    expect_val("cdb7_onehot", F_ONEHOT, 32'h0);
    drain();
    tick(); idle_inputs();
    expect_val("cdb7_empty", F_EMPTY, 32'd0);
    expect_val("cdb7_dtag", F_DTAG, 32'd7);
    drain();

    // rename r0 is ignored
    dispatch_wen = 1'b1; dispatch_addr = 5'd0; dispatch_rsaddr = 5'd0;
    tick(); idle_inputs();
    expect_val("r0_rsdata", F_RSDATA, 32'd0);
    expect_val("r0_rsvalid", F_RSVALID, 32'd1);
    expect_val("r0_rstag", F_RSTAG, 32'd0);
    expect_val("r0_dtag", F_DTAG, 32'd7);
    drain();

    // push tag 9, then rename r5 with tag 7
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'd0;
    tick(); idle_inputs();
    dispatch_wen = 1'b1; dispatch_addr = 5'd5; dispatch_ren = 1'b1; dispatch_rsaddr = 5'd5;
    tick(); idle_inputs();
    expect_val("r5_tag7", F_RSTAG, 32'd7);
    expect_val("r5_pend", F_RSVALID, 32'd0);
    expect_val("r5_dtag9", F_DTAG, 32'd9);
    drain();

    // same-cycle CDB hit and rename on r5
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'h00001234;
    dispatch_wen = 1'b1; dispatch_addr = 5'd5; dispatch_ren = 1'b1;
    #1;
    expect_val("coll_onehot", F_ONEHOT, 32'h20);
    drain();
    tick(); idle_inputs();
    expect_val("coll_debug", F_DEBUG, 32'h00001234);
    expect_val("coll_valid", F_RSVALID, 32'd0);
    expect_val("coll_tag", F_RSTAG, 32'd9);
    expect_val("coll_dtag", F_DTAG, 32'd7);
    expect_val("coll_empty", F_EMPTY, 32'd0);
    drain();

    // bypass path on r3
    dispatch_wen = 1'b1; dispatch_addr = 5'd3; dispatch_ren = 1'b1; dispatch_rsaddr = 5'd3;
    tick(); idle_inputs();
    expect_val("r3_pend", F_RSVALID, 32'd0);
    expect_val("r3_tag", F_RSTAG, 32'd7);
    expect_val("r3_empty", F_EMPTY, 32'd1);
    drain();
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'h00000055;
    #1;
    expect_val("byp_onehot", F_ONEHOT, 32'h08);
    expect_val("byp_rsdata", F_RSDATA, BYP ? 32'h55 : 32'h0);
    expect_val("byp_rsvalid", F_RSVALID, {31'd0, BYP});
    drain();
    tick(); idle_inputs();
    expect_val("r3_rsdata", F_RSDATA, 32'h55);
    expect_val("r3_rsvalid", F_RSVALID, 32'd1);
    expect_val("r3_dtag", F_DTAG, 32'd7);
    expect_val("r3_refill", F_EMPTY, 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
